// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, bubble word, sequencer states and decode helper
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE  = 6'b001111;
    localparam logic [5:0]  OP_LOAD   = 6'b010000;
    localparam logic [5:0]  OP_STORE  = 6'b010001;

    localparam logic [5:0]  FUNCT_ADD = 6'h20;
    localparam logic [5:0]  FUNCT_SUB = 6'h22;

    // load r0 <- [r15 + 0]: a harmless word the pipeline can execute as a bubble
    localparam logic [31:0] NOP_WORD  = 32'h41E0_0000;

    localparam int          REG_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic             src1_vld;
        logic [REG_W-1:0] src1;
        logic             src2_vld;
        logic [REG_W-1:0] src2;
        logic             dst_vld;
        logic [REG_W-1:0] dst;
        logic             illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] word, input logic [31:0] nop_word);
        dec_t d;
        d      = '0;
        d.src1 = word[25:21];
        d.src2 = word[20:16];
        if (word != nop_word) begin
            case (word[31:26])
                OP_RTYPE: begin
                    d.src1_vld = 1'b1;
                    d.src2_vld = 1'b1;
                    d.dst_vld  = 1'b1;
                    d.dst      = word[15:11];
                end
                OP_LOAD: begin
                    d.src1_vld = 1'b1;
                    d.dst_vld  = 1'b1;
                    d.dst      = word[20:16];
                end
                OP_STORE: begin
                    d.src1_vld = 1'b1;
                    d.src2_vld = 1'b1;
                end
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory port and instruction stream to pipeline
interface fetch_sequencer_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       inst_out;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        output imem_addr,
        output inst_out,
        output inst_valid,
        input  imem_data,
        input  inst_ready
    );

    modport slave (
        input  imem_addr,
        input  inst_out,
        input  inst_valid,
        output imem_data,
        output inst_ready
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift register of recent destinations with source compare
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             in_vld,
    input  logic [REG_W-1:0] in_reg,
    input  logic             src1_vld,
    input  logic [REG_W-1:0] src1,
    input  logic             src2_vld,
    input  logic [REG_W-1:0] src2,
    output logic             hazard
);

    logic [DEPTH-1:0] r_vld;
    logic [REG_W-1:0] r_reg [DEPTH];
    logic             w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_reg[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_reg[i] <= '0;
            end
        end else if (shift) begin
            // entry 0 is the most recent issue slot; the last entry ages out
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_reg[i] <= r_reg[i-1];
            end
            r_vld[0] <= in_vld;
            r_reg[0] <= in_reg;
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && ((src1_vld && (r_reg[i] == src1)) ||
                             (src2_vld && (r_reg[i] == src2)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign hazard = w_hazard;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetches an address range, inserting bubbles on register hazards
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          HAZ_DEPTH = 3,
    parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    fetch_sequencer_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [15:0]         bubble_count,
    output logic                illegal
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_end_addr;
    logic [31:0]       r_inst_out;
    logic              r_inst_valid;
    logic              r_done;
    logic [15:0]       r_bubble_count;
    logic              r_illegal;

    dec_t              w_dec;
    logic              w_start;
    logic              w_issue;
    logic              w_hazard;
    logic              w_advance;
    logic              w_at_end;
    logic              w_accept_last;

    assign w_dec         = decode(bus.imem_data, NOP_WORD);
    assign w_start       = (r_state == IDLE) && start;
    assign w_issue       = (r_state == RUN) && (!r_inst_valid || bus.inst_ready);
    assign w_advance     = w_issue && !w_hazard;
    assign w_at_end      = (r_pc == r_end_addr);
    assign w_accept_last = (r_state == DRAIN) && r_inst_valid && bus.inst_ready;

    hazard_scoreboard #(
        .DEPTH    (HAZ_DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_start),
        .shift    (w_issue),
        .in_vld   (!w_hazard && w_dec.dst_vld),
        .in_reg   (w_dec.dst),
        .src1_vld (w_dec.src1_vld),
        .src1     (w_dec.src1),
        .src2_vld (w_dec.src2_vld),
        .src2     (w_dec.src2),
        .hazard   (w_hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_advance && w_at_end) w_state_nxt = DRAIN;
            DRAIN:   if (w_accept_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= '0;
            r_end_addr     <= '0;
            r_inst_out     <= '0;
            r_inst_valid   <= 1'b0;
            r_done         <= 1'b0;
            r_bubble_count <= '0;
            r_illegal      <= 1'b0;
        end else begin
            r_done <= w_accept_last;
            if (w_start) begin
                r_pc           <= start_addr;
                r_end_addr     <= end_addr;
                r_bubble_count <= '0;
                r_illegal      <= 1'b0;
            end
            if (w_issue) begin
                r_inst_valid <= 1'b1;
                if (w_hazard) begin
                    // pc holds so the stalled instruction is refetched next slot
                    r_inst_out <= NOP_WORD;
                    if (r_bubble_count != 16'hFFFF) begin
                        r_bubble_count <= r_bubble_count + 16'd1;
                    end
                end else begin
                    r_inst_out <= bus.imem_data;
                    r_pc       <= r_pc + ADDR_W'(1);
                    if (w_dec.illegal) begin
                        r_illegal <= 1'b1;
                    end
                end
            end else if (w_accept_last) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign bus.imem_addr  = r_pc;
    assign bus.inst_out   = r_inst_out;
    assign bus.inst_valid = r_inst_valid;
    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign bubble_count   = r_bubble_count;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vectors for fetch_sequencer
module tb_fetch_sequencer;
    import mips_pkg::*;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic [15:0]   bubble_count;
    logic          illegal;

    logic [31:0]   mem [1024];

    fetch_sequencer_if #(.ADDR_W(AW)) bus ();

    assign bus.imem_data = mem[bus.imem_addr];

    fetch_sequencer #(
        .ADDR_W       (AW),
        .HAZ_DEPTH    (3),
        .NOP_WORD     (NOP_WORD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .bus          (bus.master),
        .busy         (busy),
        .done         (done),
        .bubble_count (bubble_count),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]     sa;
        logic [AW-1:0]     ea;
        int                stall_at;
        int                stall_len;
        int                restart_at;
        int                exp_n;
        logic [19:0][31:0] exp_seq;
        int                exp_bub;
        int                exp_done;
        logic              exp_ill;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] got_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_ld(input int rs, input int rt);
        return {OP_LOAD, 5'(rs), 5'(rt), 16'h0000};
    endfunction

    function automatic logic [31:0] enc_st(input int rs, input int rt);
        return {OP_STORE, 5'(rs), 5'(rt), 16'h0000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_vec(input int vi);
        vec_t        v;
        int          done_cyc;
        int          first_v;
        int          stall_bad;
        logic [31:0] snap_i;
        logic [AW-1:0] snap_a;
        logic        stalling;
        v         = vecs[vi];
        done_cyc  = -1;
        first_v   = -1;
        stall_bad = 0;
        snap_i    = '0;
        snap_a    = '0;
        got_q.delete();
        @(negedge clk);
        bus.inst_ready = 1'b1;
        start_addr     = v.sa;
        end_addr       = v.ea;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_after_start", vi), 32'(busy), 32'd1);
        check($sformatf("v%0d_bubbles_cleared", vi), 32'(bubble_count), 32'd0);
        check($sformatf("v%0d_illegal_cleared", vi), 32'(illegal), 32'd0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = (cyc == v.restart_at);
            if (start) begin
                start_addr = '0;
                end_addr   = '0;
            end
            stalling = (v.stall_len > 0) && (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_len);
            bus.inst_ready = !stalling;
            if (bus.inst_valid && first_v < 0) first_v = cyc;
            if (stalling) begin
                if (cyc == v.stall_at) begin
                    snap_i = bus.inst_out;
                    snap_a = bus.imem_addr;
                end else if (bus.inst_out !== snap_i || bus.imem_addr !== snap_a) begin
                    stall_bad++;
                end
            end
            if (bus.inst_valid && bus.inst_ready) got_q.push_back(bus.inst_out);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start          = 1'b0;
        bus.inst_ready = 1'b1;
        check($sformatf("v%0d_done_seen", vi), 32'(done_cyc >= 0), 32'd1);
        check($sformatf("v%0d_done_cycle", vi), 32'(done_cyc), 32'(v.exp_done));
        check($sformatf("v%0d_first_valid_cycle", vi), 32'(first_v), 32'd1);
        check($sformatf("v%0d_out_count", vi), 32'(got_q.size()), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n; i++) begin
            check($sformatf("v%0d_out%0d", vi, i),
                  (i < got_q.size()) ? got_q[i] : 32'hDEAD_DEAD, v.exp_seq[i]);
        end
        check($sformatf("v%0d_bubble_count", vi), 32'(bubble_count), 32'(v.exp_bub));
        check($sformatf("v%0d_illegal", vi), 32'(illegal), 32'(v.exp_ill));
        if (v.stall_len > 0) begin
            check($sformatf("v%0d_stall_stable", vi), 32'(stall_bad), 32'd0);
        end
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", vi), 32'(done), 32'd0);
        check($sformatf("v%0d_idle_busy", vi), 32'(busy), 32'd0);
        check($sformatf("v%0d_idle_valid", vi), 32'(bus.inst_valid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},   32'(bus.inst_valid), 32'd0);
        check({tag, "_inst"},    bus.inst_out, 32'd0);
        check({tag, "_addr"},    32'(bus.imem_addr), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_done"},    32'(done), 32'd0);
        check({tag, "_bubbles"}, 32'(bubble_count), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        logic [31:0] n;
        n = NOP_WORD;
        for (int i = 0; i < 1024; i++) mem[i] = NOP_WORD;

        mem[0]  = enc_ld(0, 1);
        mem[1]  = enc_ld(0, 2);
        mem[2]  = enc_st(4, 5);
        mem[3]  = enc_r(1, 2, 3, FUNCT_ADD);
        mem[4]  = enc_ld(7, 6);
        mem[5]  = enc_st(6, 3);
        mem[6]  = enc_r(9, 10, 8, FUNCT_ADD);
        mem[7]  = enc_r(8, 12, 11, FUNCT_SUB);
        mem[8]  = NOP_WORD;

        mem[9]  = enc_st(30, 29);
        mem[10] = enc_ld(31, 1);
        mem[14] = enc_r(1, 1, 2, FUNCT_ADD);
        for (int a = 15; a <= 25; a++) mem[a] = enc_ld(31, a - 10);

        mem[30]   = enc_ld(31, 1);
        mem[31]   = enc_st(31, 30);
        mem[32]   = 32'hFC00_1234;
        mem[1023] = enc_ld(31, 5);

        // v0: hazard-free program with hand NOPs
        vecs[0] = '{sa: 10'd9, ea: 10'd25, stall_at: 0, stall_len: 0, restart_at: -1,
                    exp_n: 17, exp_seq: '0, exp_bub: 0, exp_done: 18, exp_ill: 1'b0};
        for (int i = 0; i < 17; i++) vecs[0].exp_seq[i] = mem[9 + i];

        // v1: dependent program, bubbles worked out by hand
        vecs[1] = '{sa: 10'd0, ea: 10'd8, stall_at: 0, stall_len: 0, restart_at: -1,
                    exp_n: 17, exp_seq: '0, exp_bub: 8, exp_done: 18, exp_ill: 1'b0};
        vecs[1].exp_seq[0]  = mem[0];
        vecs[1].exp_seq[1]  = mem[1];
        vecs[1].exp_seq[2]  = mem[2];
        vecs[1].exp_seq[3]  = n;
        vecs[1].exp_seq[4]  = n;
        vecs[1].exp_seq[5]  = mem[3];
        vecs[1].exp_seq[6]  = mem[4];
        vecs[1].exp_seq[7]  = n;
        vecs[1].exp_seq[8]  = n;
        vecs[1].exp_seq[9]  = n;
        vecs[1].exp_seq[10] = mem[5];
        vecs[1].exp_seq[11] = mem[6];
        vecs[1].exp_seq[12] = n;
        vecs[1].exp_seq[13] = n;
        vecs[1].exp_seq[14] = n;
        vecs[1].exp_seq[15] = mem[7];
        vecs[1].exp_seq[16] = mem[8];

        // v2: same program, pipeline stalls 4 cycles
        vecs[2] = vecs[1];
        vecs[2].stall_at  = 5;
        vecs[2].stall_len = 4;
        vecs[2].exp_done  = 22;

        // v3: wrap through the top of memory
        vecs[3] = '{sa: 10'd1023, ea: 10'd1, stall_at: 0, stall_len: 0, restart_at: -1,
                    exp_n: 3, exp_seq: '0, exp_bub: 0, exp_done: 4, exp_ill: 1'b0};
        vecs[3].exp_seq[0] = mem[1023];
        vecs[3].exp_seq[1] = mem[0];
        vecs[3].exp_seq[2] = mem[1];

        // v4: unknown opcode as last instruction
        vecs[4] = '{sa: 10'd30, ea: 10'd32, stall_at: 0, stall_len: 0, restart_at: -1,
                    exp_n: 3, exp_seq: '0, exp_bub: 0, exp_done: 4, exp_ill: 1'b1};
        vecs[4].exp_seq[0] = mem[30];
        vecs[4].exp_seq[1] = mem[31];
        vecs[4].exp_seq[2] = 32'hFC00_1234;

        // v5: start pulsed mid-run must be ignored
        vecs[5] = vecs[0];
        vecs[5].restart_at = 3;

        rst_n          = 1'b0;
        start          = 1'b0;
        start_addr     = '0;
        end_addr       = '0;
        bus.inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;

        run_vec(0);
        run_vec(1);
        run_vec(2);
        run_vec(5);
        run_vec(4);
        repeat (3) @(negedge clk);
        check("illegal_sticky_idle", 32'(illegal), 32'd1);
        run_vec(3);

        // abort mid-run with reset, then a clean rerun
        @(negedge clk);
        start_addr = 10'd0;
        end_addr   = 10'd8;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_bubbles", 32'(bubble_count), 32'd2);
        check("pre_reset_valid", 32'(bus.inst_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 32'd0);
        end
        run_vec(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, instruction memory word-address width.
REQ-002 Parameter HAZ_DEPTH, default 3, number of issued slots a destination register stays unreadable.
REQ-003 Parameter NOP_WORD, default 32'h41E0_0000, bubble encoding (load, rs=15, rt=0, offset 0).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a run.
REQ-007 start_addr  input  ADDR_W  first fetch address, sampled on start.
REQ-008 end_addr  input  ADDR_W  last fetch address (inclusive), sampled on start.
REQ-009 imem_addr  output  ADDR_W  address to instruction memory; equals pc combinationally.
REQ-010 imem_data  input  32  instruction word for imem_addr, same cycle.
REQ-011 inst_out  output  32  registered instruction to pipeline.
REQ-012 inst_valid  output  1  inst_out holds an instruction or bubble.
REQ-013 inst_ready  input  1  pipeline accepts inst_out this cycle.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 done  output  1  one-cycle pulse when last output accepted.
REQ-016 bubble_count  output  16  bubbles inserted in current run, saturating.
REQ-017 illegal  output  1  sticky; an unknown opcode was issued this run.

Function
REQ-018 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when end_addr instruction is loaded into inst_out; DRAIN->IDLE when that instruction is accepted, pulsing done.
REQ-019 start in RUN or DRAIN SHALL be ignored.
REQ-020 On start: pc<=start_addr, scoreboard cleared, bubble_count<=0, illegal<=0.
REQ-021 Issue slot SHALL occur in RUN when !inst_valid || inst_ready; otherwise inst_out, pc, scoreboard hold.
REQ-022 Decode: opcode 001111 R-type (src rs, rt; dst rd); 010000 load (src rs; dst rt); 010001 store (src rs, rt; no dst); word equal NOP_WORD: no src, no dst; any other opcode: no src, no dst, sets illegal on issue.
REQ-023 Hazard SHALL be any src equal to a valid destination in the HAZ_DEPTH-entry scoreboard.
REQ-024 On issue slot with hazard: inst_out<=NOP_WORD, pc holds, bubble_count++ (saturate at 16'hFFFF), scoreboard shifts in an invalid entry.
REQ-025 On issue slot without hazard: inst_out<=imem_data, pc<=pc+1 (wrap 2^ADDR_W-1 -> 0), scoreboard shifts in dst (valid only if instruction has dst).
REQ-026 Scoreboard SHALL shift only on issue slots; oldest entry discarded.
REQ-027 In DRAIN and IDLE no issue slots occur; inst_valid clears when last word accepted.
REQ-028 Latency: first instruction valid one cycle after start.
REQ-029 start_addr==end_addr SHALL run exactly one instruction; end_addr<start_addr runs through wrap.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, pc=0, inst_out=0, inst_valid=0, busy=0, done=0, bubble_count=0, illegal=0, scoreboard all invalid; mid-run reset aborts without done.

Structure
REQ-031 Opcode/funct constants, NOP_WORD, state enum in shared package mips_pkg.
REQ-032 One sub-module, hazard_scoreboard (shift register plus compare), instantiated once.

Verification
REQ-033 start_addr=9, end_addr=25, program with hand NOPs, inst_ready=1 -> 17 instructions in address order, bubble_count=0, done 18 cycles after start.
REQ-034 start_addr=0, end_addr=8 (no hand NOPs) -> 5 bubbles before mem[5]... exact sequence matches scoreboard model; sub at mem[7] preceded by 3 bubbles after add.
REQ-035 inst_ready low 4 cycles mid-run -> inst_out stable, pc stable, no extra bubbles.
REQ-036 start_addr=1023, end_addr=1 -> fetches 1023,0,1 then done.
REQ-037 rst_n asserted mid-run, then start_addr=0 -> outputs at reset values immediately, clean rerun, illegal=0.
REQ-038 Opcode 111111 at end_addr -> issued unchanged, illegal=1 until next start.
